axil_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file; successor to the fixed four-register myreg1 slave. It provides NUM_REGS software-visible registers of DATA_WIDTH bits, with byte-strobe writes, per-register read-only status inputs and per-register write-strobe pulses. It sits behind the block-design AXI interconnect as a control/status bank for NPU core logic.

---
 rtl/axil_regfile_pkg.sv | 29 ++
 rtl/axil_regfile_wr_ch.sv | 135 +++++++++++++
 rtl/axil_regfile.sv | 177 +++++++++++++++++
 tb/tb_axil_regfile.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regfile_pkg.sv
// -----------------------------------------------------------------------------
// axil_regfile_pkg
// Shared definitions for the axil_regfile AXI4-Lite register bank:
//   - RESP_OKAY / RESP_SLVERR : AXI response codes used on bresp/rresp
//   - wr_state_e              : write-channel FSM states
//   - rd_state_e              : read-channel FSM states
//   - addr_lsb()              : number of byte-offset address bits per word
// -----------------------------------------------------------------------------
package axil_regfile_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_COMMIT = 2'd1,
      W_RESP   = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_VALID = 1'b1
   } rd_state_e;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axil_regfile_wr_ch.sv
// -----------------------------------------------------------------------------
// axil_regfile_wr_ch
// AXI4-Lite write-address / write-data capture and write-response FSM.
// AW and W are accepted independently (either order or together); once both
// are held the FSM spends one W_COMMIT cycle presenting the write to the
// register storage, then holds bvalid until bready.
//
// Optional feature macro: AXIL_REGFILE_SLVERR_EN
//   defined     : writes to an index >= NUM_REGS answer bresp = SLVERR
//   not defined : every write answers OKAY
//
// Ports
//   ACLK, ARESETN             clock, asynchronous active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_b*  AXI4-Lite write channels (awprot handled in top)
//   commit                    high for the single W_COMMIT cycle
//   commit_idx                register index of the committing write
//   commit_data, commit_strb  write data and byte strobes of that write
// -----------------------------------------------------------------------------
module axil_regfile_wr_ch
   import axil_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_REGS   = 8,
   localparam int ADDR_LSB  = addr_lsb(DATA_WIDTH),
   localparam int IDX_W     = ADDR_WIDTH - ADDR_LSB,
   localparam int STRB_W    = DATA_WIDTH / 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [STRB_W-1:0]     s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic                  commit,
   output logic [IDX_W-1:0]      commit_idx,
   output logic [DATA_WIDTH-1:0] commit_data,
   output logic [STRB_W-1:0]     commit_strb
);

   wr_state_e             state;
   logic                  aw_done;
   logic                  w_done;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  aw_done_nx;
   logic                  w_done_nx;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [STRB_W-1:0]     strb_q;
   logic [1:0]            commit_resp;
   logic                  unused_ok;

   // The low byte-offset bits never select anything.
   assign unused_ok = ^s_axi_awaddr[ADDR_LSB-1:0];

   // Readies are only ever high in W_IDLE, so a handshake implies W_IDLE.
   assign aw_hs      = s_axi_awvalid & s_axi_awready;
   assign w_hs       = s_axi_wvalid & s_axi_wready;
   assign aw_done_nx = aw_done | aw_hs;
   assign w_done_nx  = w_done | w_hs;

`ifdef AXIL_REGFILE_SLVERR_EN
   assign commit_resp = (int'(idx_q) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
`else
   assign commit_resp = RESP_OKAY;
`endif

   // Control path: readies are registered and computed from next-state so
   // that they never depend combinationally on a valid input.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= W_IDLE;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
      end else begin
         case (state)
            W_IDLE: begin
               if (aw_done_nx && w_done_nx) begin
                  state         <= W_COMMIT;
                  aw_done       <= 1'b0;
                  w_done        <= 1'b0;
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b0;
               end else begin
                  aw_done       <= aw_done_nx;
                  w_done        <= w_done_nx;
                  s_axi_awready <= !aw_done_nx;
                  s_axi_wready  <= !w_done_nx;
               end
            end
            W_COMMIT: begin
               state        <= W_RESP;
               s_axi_bvalid <= 1'b1;
               s_axi_bresp  <= commit_resp;
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  state         <= W_IDLE;
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  s_axi_wready  <= 1'b1;
               end
            end
            default: state <= W_IDLE;
         endcase
      end
   end

   // Captured address/data are only consumed while the control path says so,
   // so they carry no reset.
   always_ff @(posedge ACLK) begin
      if (aw_hs) idx_q <= s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
         data_q <= s_axi_wdata;
         strb_q <= s_axi_wstrb;
      end
   end

   assign commit      = (state == W_COMMIT);
   assign commit_idx  = idx_q;
   assign commit_data = data_q;
   assign commit_strb = strb_q;

endmodule

// File: rtl/axil_regfile.sv
// -----------------------------------------------------------------------------
// axil_regfile
// Parametrised AXI4-Lite slave register bank (control/status for NPU logic).
// NUM_REGS registers of DATA_WIDTH bits with byte-strobe writes. Registers
// whose RO_MASK bit is set are read-only and mirror reg_in.
//
// Optional feature macro: AXIL_REGFILE_SLVERR_EN
//   defined     : out-of-range reads/writes answer SLVERR (reads return 0)
//   not defined : out-of-range reads/writes answer OKAY (reads return 0)
//
// Ports
//   ACLK, ARESETN      clock, asynchronous active-low reset
//   s_axi_*            AXI4-Lite slave (awprot/arprot ignored)
//   reg_out            flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_in             status inputs, used only for read-only registers
//   wr_pulse           one-cycle pulse per committed write to a writable register
// -----------------------------------------------------------------------------
module axil_regfile
   import axil_regfile_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADDR_WIDTH = 6,
   parameter int                  NUM_REGS   = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
   localparam int                 ADDR_LSB   = addr_lsb(DATA_WIDTH),
   localparam int                 IDX_W      = ADDR_WIDTH - ADDR_LSB,
   localparam int                 STRB_W     = DATA_WIDTH / 8
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic [2:0]                     s_axi_awprot,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [STRB_W-1:0]              s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic [2:0]                     s_axi_arprot,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || (NUM_REGS > (1 << IDX_W))) begin : g_bad_cfg
      $error("axil_regfile: illegal DATA_WIDTH / NUM_REGS / ADDR_WIDTH combination");
   end

   logic                  commit;
   logic [IDX_W-1:0]      commit_idx;
   logic [DATA_WIDTH-1:0] commit_data;
   logic [STRB_W-1:0]     commit_strb;

   rd_state_e             rstate;
   logic                  ar_hs;
   logic [IDX_W-1:0]      ar_idx;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [1:0]            rd_resp;
   logic                  unused_ok;

   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[ADDR_LSB-1:0]};

   axil_regfile_wr_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_wr_ch (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .commit        (commit),
      .commit_idx    (commit_idx),
      .commit_data   (commit_data),
      .commit_strb   (commit_strb)
   );

   // Register storage. Read-only slots are plain wires from reg_in, so the
   // read mux below sees the live status value at the AR handshake.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
         assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
         assign wr_pulse[gi] = 1'b0;
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] q;
         logic                  hit;
         logic [DATA_WIDTH-1:0] unused_reg_in;

         assign unused_reg_in = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
         assign hit = commit && (int'(commit_idx) == gi);

         always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
               q <= '0;
            end else if (hit) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (commit_strb[b]) q[b*8 +: 8] <= commit_data[b*8 +: 8];
               end
            end
         end

         assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = q;
         assign wr_pulse[gi] = hit;
      end
   end

   // Read mux: an index with no matching register falls through to zero.
   assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(ar_idx) == i) rd_val = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

`ifdef AXIL_REGFILE_SLVERR_EN
   assign rd_resp = (int'(ar_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
`else
   assign rd_resp = RESP_OKAY;
`endif

   assign ar_hs = s_axi_arvalid & s_axi_arready;

   // Read channel: rdata is captured at the AR handshake, so a write that
   // commits in the same cycle is not yet visible.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rstate        <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  rstate        <= R_VALID;
                  s_axi_arready <= 1'b0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rdata   <= rd_val;
                  s_axi_rresp   <= rd_resp;
               end else begin
                  s_axi_arready <= 1'b1;
               end
            end
            R_VALID: begin
               if (s_axi_rready) begin
                  rstate        <= R_IDLE;
                  s_axi_rvalid  <= 1'b0;
                  s_axi_arready <= 1'b1;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_regfile.sv
// -----------------------------------------------------------------------------
// tb_axil_regfile
// Self-checking bench for axil_regfile (DATA_WIDTH=32, NUM_REGS=8, reg 7 RO).
// Drivers push expected B/R responses into queues; monitors pop and compare
// whenever the DUT completes a response handshake. Expected values come from
// a word-array model of the register file.
// -----------------------------------------------------------------------------
module tb_axil_regfile;

   localparam int             DW  = 32;
   localparam int             AW  = 6;
   localparam int             NR  = 8;
   localparam logic [NR-1:0]  RO  = 8'b1000_0000;
   localparam int             TMO = 40;
`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0]     OOR_RESP = 2'b10;
`else
   localparam logic [1:0]     OOR_RESP = 2'b00;
`endif

   logic              ACLK;
   logic              ARESETN;
   logic [AW-1:0]     s_axi_awaddr;
   logic [2:0]        s_axi_awprot;
   logic              s_axi_awvalid;
   logic              s_axi_awready;
   logic [DW-1:0]     s_axi_wdata;
   logic [DW/8-1:0]   s_axi_wstrb;
   logic              s_axi_wvalid;
   logic              s_axi_wready;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bvalid;
   logic              s_axi_bready;
   logic [AW-1:0]     s_axi_araddr;
   logic [2:0]        s_axi_arprot;
   logic              s_axi_arvalid;
   logic              s_axi_arready;
   logic [DW-1:0]     s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid;
   logic              s_axi_rready;
   logic [NR*DW-1:0]  reg_out;
   logic [NR*DW-1:0]  reg_in;
   logic [NR-1:0]     wr_pulse;

   axil_regfile #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .RO_MASK    (RO)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (s_axi_arprot),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .reg_out       (reg_out),
      .reg_in        (reg_in),
      .wr_pulse      (wr_pulse)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
   } rexp_t;

   logic [31:0] mdl [NR];
   int          exp_pulse [NR];
   int          act_pulse [NR];
   logic [1:0]  exp_b [$];
   rexp_t       exp_r [$];
   int          checks;
   int          failures;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endfunction

   function automatic void timeout(string nm);
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=no_handshake required=handshake", nm);
   endfunction

   // Response monitors.
   always @(negedge ACLK) begin
      if (ARESETN) begin
         if (s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_unexpected actual=bvalid required=no_response");
            end else begin
               chk("bresp", s_axi_bresp, exp_b.pop_front());
            end
         end
         if (s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL r_unexpected actual=rvalid required=no_response");
            end else begin
               rexp_t e;
               e = exp_r.pop_front();
               chk("rdata", s_axi_rdata, e.d);
               chk("rresp", s_axi_rresp, e.r);
            end
         end
         for (int i = 0; i < NR; i++) if (wr_pulse[i]) act_pulse[i]++;
      end
   end

   // Channel drivers. All start shortly after a rising edge.
   task automatic aw_phase(input logic [AW-1:0] a, input int dly);
      repeat (dly) @(posedge ACLK);
      #1;
      s_axi_awaddr  = a;
      s_axi_awvalid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge ACLK);
         if (s_axi_awready) break;
         if (n >= TMO) begin timeout("aw"); break; end
      end
      @(posedge ACLK);
      #1 s_axi_awvalid = 1'b0;
   endtask

   task automatic w_phase(input logic [31:0] d, input logic [3:0] s, input int dly);
      repeat (dly) @(posedge ACLK);
      #1;
      s_axi_wdata  = d;
      s_axi_wstrb  = s;
      s_axi_wvalid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge ACLK);
         if (s_axi_wready) break;
         if (n >= TMO) begin timeout("w"); break; end
      end
      @(posedge ACLK);
      #1 s_axi_wvalid = 1'b0;
   endtask

   task automatic b_phase(input int dly);
      repeat (dly) @(posedge ACLK);
      #1 s_axi_bready = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge ACLK);
         if (s_axi_bvalid) break;
         if (n >= TMO) begin timeout("b"); break; end
      end
      @(posedge ACLK);
      #1 s_axi_bready = 1'b0;
   endtask

   task automatic ar_phase(input logic [AW-1:0] a, input int dly);
      repeat (dly) @(posedge ACLK);
      #1;
      s_axi_araddr  = a;
      s_axi_arvalid = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge ACLK);
         if (s_axi_arready) break;
         if (n >= TMO) begin timeout("ar"); break; end
      end
      @(posedge ACLK);
      #1 s_axi_arvalid = 1'b0;
   endtask

   task automatic r_phase(input int dly);
      repeat (dly) @(posedge ACLK);
      #1 s_axi_rready = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge ACLK);
         if (s_axi_rvalid) break;
         if (n >= TMO) begin timeout("r"); break; end
      end
      @(posedge ACLK);
      #1 s_axi_rready = 1'b0;
   endtask

   // Reference model: a write lands byte-by-byte on writable in-range words.
   task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(a[AW-1:2]);
      if (idx >= NR) begin
         exp_b.push_back(OOR_RESP);
      end else begin
         exp_b.push_back(2'b00);
         if (!RO[idx]) begin
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
            exp_pulse[idx]++;
         end
      end
   endtask

   task automatic check_reg_out(input logic [AW-1:0] a);
      int idx;
      idx = int'(a[AW-1:2]);
      if (idx < NR && !RO[idx]) chk($sformatf("reg_out_%0d", idx), reg_out[idx*32 +: 32], mdl[idx]);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd);
      model_write(a, d, s);
      fork
         aw_phase(a, awd);
         w_phase(d, s, wd);
      join
      b_phase(bd);
      check_reg_out(a);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int ad, input int rd);
      int    idx;
      rexp_t e;
      idx = int'(a[AW-1:2]);
      if (idx >= NR) begin
         e.d = 32'h0;
         e.r = OOR_RESP;
      end else if (RO[idx]) begin
         e.d = reg_in[idx*32 +: 32];
         e.r = 2'b00;
      end else begin
         e.d = mdl[idx];
         e.r = 2'b00;
      end
      exp_r.push_back(e);
      ar_phase(a, ad);
      r_phase(rd);
   endtask

   task automatic check_pulses();
      for (int i = 0; i < NR; i++) chk($sformatf("pulses_%0d", i), act_pulse[i], exp_pulse[i]);
   endtask

   task automatic check_all_regs();
      for (int i = 0; i < NR; i++) begin
         if (!RO[i]) chk($sformatf("reg_out_%0d", i), reg_out[i*32 +: 32], mdl[i]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks        = 0;
      failures      = 0;
      ARESETN       = 1'b0;
      s_axi_awaddr  = '0;
      s_axi_awprot  = '0;
      s_axi_awvalid = 1'b0;
      s_axi_wdata   = '0;
      s_axi_wstrb   = '0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      s_axi_araddr  = '0;
      s_axi_arprot  = '0;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      for (int i = 0; i < NR; i++) begin
         mdl[i]       = 32'h0;
         exp_pulse[i] = 0;
         act_pulse[i] = 0;
         reg_in[i*32 +: 32] = $urandom;
      end
      reg_in[7*32 +: 32] = 32'hCAFE0001;

      // Reset state.
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_awready", s_axi_awready, 0);
      chk("rst_wready", s_axi_wready, 0);
      chk("rst_arready", s_axi_arready, 0);
      chk("rst_bvalid", s_axi_bvalid, 0);
      chk("rst_rvalid", s_axi_rvalid, 0);
      chk("rst_bresp", s_axi_bresp, 0);
      chk("rst_rresp", s_axi_rresp, 0);
      chk("rst_rdata", s_axi_rdata, 0);
      chk("rst_wr_pulse", wr_pulse, 0);
      check_all_regs();
      @(posedge ACLK);
      #1 ARESETN = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      chk("post_rst_awready", s_axi_awready, 1);
      chk("post_rst_wready", s_axi_wready, 1);
      chk("post_rst_arready", s_axi_arready, 1);
      @(posedge ACLK);
      #1;

      // Sequential writes then read-back.
      for (int i = 0; i < 4; i++) do_write(AW'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) do_read(AW'(i*4), 0, 0);
      check_pulses();

      // Byte-strobe merge.
      do_write(6'h04, 32'h11111111, 4'hF, 0, 0, 0);
      do_write(6'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      do_read(6'h04, 0, 0);

      // AW well ahead of W: nothing commits until W arrives.
      model_write(6'h08, 32'h12345678, 4'hF);
      aw_phase(6'h08, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK);
         chk("aw_early_awready", s_axi_awready, 0);
         chk("aw_early_wready", s_axi_wready, 1);
         chk("aw_early_pulse", wr_pulse, 0);
         chk("aw_early_bvalid", s_axi_bvalid, 0);
      end
      @(posedge ACLK);
      w_phase(32'h12345678, 4'hF, 0);
      b_phase(0);
      check_reg_out(6'h08);

      // Read-only register.
      do_write(6'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      do_read(6'h1C, 0, 0);

      // bready held low: B stays up and no new write is accepted.
      model_write(6'h0C, 32'hBEEF0003, 4'hF);
      fork
         aw_phase(6'h0C, 0);
         w_phase(32'hBEEF0003, 4'hF, 0);
      join
      for (int n = 0; ; n++) begin
         @(negedge ACLK);
         if (s_axi_bvalid) break;
         if (n >= TMO) begin timeout("b_hold"); break; end
      end
      for (int k = 0; k < 5; k++) begin
         chk("bhold_bvalid", s_axi_bvalid, 1);
         chk("bhold_awready", s_axi_awready, 0);
         chk("bhold_wready", s_axi_wready, 0);
         @(negedge ACLK);
      end
      @(posedge ACLK);
      b_phase(0);
      do_write(6'h10, 32'h55AA55AA, 4'hF, 0, 0, 0);
      do_read(6'h0C, 0, 0);

      // Out-of-range accesses.
      do_write(6'h3C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      do_read(6'h3C, 0, 0);
      check_all_regs();

      // Randomized traffic.
      for (int it = 0; it < 80; it++) begin
         logic [AW-1:0] a;
         for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = $urandom;
         a = AW'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      check_pulses();
      check_all_regs();

      // Reset between AW and W handshakes.
      aw_phase(6'h04, 0);
      ARESETN = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
      @(negedge ACLK);
      chk("midrst_awready", s_axi_awready, 0);
      chk("midrst_bvalid", s_axi_bvalid, 0);
      check_all_regs();
      @(posedge ACLK);
      #1 ARESETN = 1'b1;
      for (int i = 0; i < NR; i++) do_read(AW'(i*4), 0, 0);
      // A lone W must not complete the aborted AW.
      model_write(6'h00, 32'hDEADBEEF, 4'hF);
      w_phase(32'hDEADBEEF, 4'hF, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK);
         chk("midrst_pulse", wr_pulse, 0);
         chk("midrst_no_b", s_axi_bvalid, 0);
      end
      @(posedge ACLK);
      aw_phase(6'h00, 0);
      b_phase(0);
      for (int i = 0; i < NR; i++) do_read(AW'(i*4), 0, 1);
      check_pulses();
      check_all_regs();

      repeat (3) @(posedge ACLK);
      chk("b_queue_empty", exp_b.size(), 0);
      chk("r_queue_empty", exp_r.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
